reg_writeback_queue: RTL and testbench

Write-side sequencer for the 4×8-bit register file. It accepts result writes from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO. It drains the FIFO at no more than one write per cycle onto the register file's `write`/`write_reg`/`write_data` port. An optional bypass lookup reports the newest pending value for up to two register addresses, so the operand-fetch path sees data not yet committed.

---
 rtl/reg_writeback_queue.sv | 167 ++++++++++++++++
 tb/tb_reg_writeback_queue.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// reg_writeback_queue
//
// Write-side sequencer for the 4x8-bit register file. Result writes from the
// execute/memory stages arrive over a valid/ready handshake and are buffered
// in a small in-order FIFO. The FIFO drains at most one entry per cycle into
// a registered output stage that drives the register file write port.
//
// An optional bypass lookup (compiled in when the macro REG_WB_BYPASS_EN is
// defined) reports the newest pending value for two lookup addresses, so the
// operand-fetch path can see data that has not yet been committed. Without
// the macro the fwd_* outputs are tied to zero and queue behaviour is
// unchanged.
//
// Parameters:
//   DEPTH       FIFO entries, a power of two, at least 2
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous active-high reset, clears all state
//   flush       synchronous discard of all queued and staged writes
//   in_valid    producer has a write to enqueue
//   in_ready    queue can accept a write this cycle (not full)
//   in_reg      destination register index of the incoming write
//   in_data     value of the incoming write
//   wr_hold     register-file side stall, blocks dequeue
//   write       registered register-file write strobe
//   write_reg   registered register-file write index
//   write_data  registered register-file write data
//   chk_reg1/2  bypass lookup addresses
//   fwd_hit1/2  a pending write exists for the lookup address
//   fwd_data1/2 newest pending value for the lookup address (0 on a miss)
// ---------------------------------------------------------------------------
module reg_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_reg,
    input  logic [7:0] in_data,
    input  logic       wr_hold,
    output logic       write,
    output logic [1:0] write_reg,
    output logic [7:0] write_data,
    input  logic [1:0] chk_reg1,
    input  logic [1:0] chk_reg2,
    output logic       fwd_hit1,
    output logic       fwd_hit2,
    output logic [7:0] fwd_data1,
    output logic [7:0] fwd_data2
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [1:0]       ent_reg  [DEPTH];
    logic [7:0]       ent_data [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready is decoded from the occupancy alone so a full queue never
    // accepts, even in a cycle that also dequeues; this keeps in_ready free
    // of any combinational path from wr_hold.
    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && !wr_hold;

    // FIFO storage, pointers, occupancy and the registered output stage.
    // Reset outranks flush, and flush outranks any push or pop in the same
    // cycle. Flush leaves write_reg/write_data holding their old values but
    // drops the strobe, so nothing discarded ever reaches the register file.
    // Pointers are PTR_W bits wide and therefore wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            write      <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i]  <= '0;
                ent_data[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            write  <= 1'b0;
        end else begin
            write <= pop;
            if (pop) begin
                write_reg  <= ent_reg[rd_ptr];
                write_data <= ent_data[rd_ptr];
                rd_ptr     <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                ent_reg[wr_ptr]  <= in_reg;
                ent_data[wr_ptr] <= in_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

`ifdef REG_WB_BYPASS_EN
    logic [PTR_W-1:0] slot;

    // Bypass lookup. Candidates are visited from oldest to newest (output
    // stage first, then the FIFO from head to tail) and every match
    // overwrites the previous one, so the last match seen is the newest
    // pending value. Only occupied slots take part; a push in the current
    // cycle is not yet in the storage and is therefore invisible.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        slot      = '0;
        if (write) begin
            if (write_reg == chk_reg1) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = write_data;
            end
            if (write_reg == chk_reg2) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = write_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) begin
                if (ent_reg[slot] == chk_reg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent_data[slot];
                end
                if (ent_reg[slot] == chk_reg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent_data[slot];
                end
            end
        end
    end
`else
    logic unused_chk;

    // Without the bypass the lookup addresses are not needed; fold them into
    // a deliberately unused signal and hold the forwarding outputs at zero.
    assign unused_chk = ^{chk_reg1, chk_reg2};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_queue
//
// Self-checking bench for reg_writeback_queue. A queue-based reference model
// tracks the pending writes and the output stage; directed scenarios check
// against fixed expected values, and a randomized run checks every output
// against the model each cycle. Bypass expectations follow REG_WB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_reg_writeback_queue;

    localparam int DEPTH = 4;
`ifdef REG_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_reg;
    logic [7:0] in_data;
    logic       wr_hold;
    logic       write;
    logic [1:0] write_reg;
    logic [7:0] write_data;
    logic [1:0] chk_reg1;
    logic [1:0] chk_reg2;
    logic       fwd_hit1;
    logic       fwd_hit2;
    logic [7:0] fwd_data1;
    logic [7:0] fwd_data2;

    int tests_run;
    int tests_failed;

    // Reference model: pending FIFO entries {reg, data} oldest first, plus
    // the output stage.
    logic [9:0] mq[$];
    logic       m_write;
    logic [1:0] m_reg;
    logic [7:0] m_data;

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_reg    (in_reg),
        .in_data   (in_data),
        .wr_hold   (wr_hold),
        .write     (write),
        .write_reg (write_reg),
        .write_data(write_data),
        .chk_reg1  (chk_reg1),
        .chk_reg2  (chk_reg2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle worth of producer inputs.
    task automatic applyStimulus(input logic v, input logic [1:0] r, input logic [7:0] d,
                                 input logic h, input logic f);
        in_valid = v;
        in_reg   = r;
        in_data  = d;
        wr_hold  = h;
        flush    = f;
    endtask

    // Advance one rising edge and update the model from the pre-edge inputs.
    task automatic tick();
        bit         ready;
        bit         do_push;
        bit         do_pop;
        logic [9:0] head;
        ready   = (mq.size() != DEPTH);
        do_push = in_valid && ready;
        do_pop  = (mq.size() != 0) && !wr_hold;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_write = 1'b0;
            m_reg   = 2'd0;
            m_data  = 8'd0;
        end else if (flush) begin
            mq.delete();
            m_write = 1'b0;
        end else begin
            if (do_pop) begin
                head    = mq.pop_front();
                m_write = 1'b1;
                m_reg   = head[9:8];
                m_data  = head[7:0];
            end else begin
                m_write = 1'b0;
            end
            if (do_push) mq.push_back({in_reg, in_data});
        end
        #1;
    endtask

    // Newest pending value for a register address in the model.
    function automatic void model_fwd(input logic [1:0] r, output logic hit, output logic [7:0] d);
        hit = 1'b0;
        d   = 8'd0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i][9:8] == r) begin
                hit = 1'b1;
                d   = mq[i][7:0];
                break;
            end
        end
        if (!hit && m_write && m_reg == r) begin
            hit = 1'b1;
            d   = m_data;
        end
        if (!BYP) begin
            hit = 1'b0;
            d   = 8'd0;
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b1, 2'd1, 8'hFF, 1'b0, 1'b0);
        chk_reg1 = 2'd0;
        chk_reg2 = 2'd1;
        tick();
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        #1;
        tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_write: got %0b expected 0", write); end
        tests_run++; if (write_reg !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_write_reg: got %0d expected 0", write_reg); end
        tests_run++; if (write_data !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_write_data: got %h expected 00", write_data); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
        tests_run++; if ({fwd_hit1, fwd_hit2} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_fwd_hit: got %b expected 00", {fwd_hit1, fwd_hit2}); end
        tests_run++; if ({fwd_data1, fwd_data2} !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_fwd_data: got %h expected 0000", {fwd_data1, fwd_data2}); end
    endtask

    task automatic test_latency();
        do_reset();
        applyStimulus(1'b1, 2'd2, 8'h5A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_edge1_write: got %0b expected 0", write); end
        tick();
        chk_reg1 = 2'd2;
        chk_reg2 = 2'd0;
        #1;
        tests_run++; if ({write, write_reg, write_data} !== {1'b1, 2'd2, 8'h5A}) begin tests_failed++; $display("[TB] FAIL lat_edge2_strobe: got %0b/%0d/%h expected 1/2/5a", write, write_reg, write_data); end
        tests_run++; if ({fwd_hit1, fwd_data1} !== {BYP, BYP ? 8'h5A : 8'h00}) begin tests_failed++; $display("[TB] FAIL lat_stage_bypass: got %0b/%h expected %0b/%h", fwd_hit1, fwd_data1, BYP, BYP ? 8'h5A : 8'h00); end
        tests_run++; if (fwd_hit2 !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_stage_miss: got %0b expected 0", fwd_hit2); end
        tick();
        tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_edge3_write: got %0b expected 0", write); end
    endtask

    task automatic test_hold_fill();
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'(i), vals[i], 1'b1, 1'b0);
            tick();
            tests_run++; if (in_ready !== (i < 3)) begin tests_failed++; $display("[TB] FAIL fill_ready_%0d: got %0b expected %0b", i, in_ready, (i < 3)); end
            tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_held_write_%0d: got %0b expected 0", i, write); end
        end
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if ({write, write_reg, write_data} !== {1'b1, 2'(i), vals[i]}) begin tests_failed++; $display("[TB] FAIL drain_%0d: got %0b/%0d/%h expected 1/%0d/%h", i, write, write_reg, write_data, i, vals[i]); end
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_ready_%0d: got %0b expected 1", i, in_ready); end
        end
        tick();
        tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_done: got %0b expected 0", write); end
    endtask

    task automatic test_bypass();
        do_reset();
        applyStimulus(1'b1, 2'd1, 8'h10, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd1, 8'h20, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
        chk_reg1 = 2'd1;
        chk_reg2 = 2'd3;
        #1;
        tests_run++; if ({fwd_hit1, fwd_data1} !== {BYP, BYP ? 8'h20 : 8'h00}) begin tests_failed++; $display("[TB] FAIL byp_newest: got %0b/%h expected %0b/%h", fwd_hit1, fwd_data1, BYP, BYP ? 8'h20 : 8'h00); end
        tests_run++; if ({fwd_hit2, fwd_data2} !== {1'b0, 8'h00}) begin tests_failed++; $display("[TB] FAIL byp_miss: got %0b/%h expected 0/00", fwd_hit2, fwd_data2); end
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        tick();
        tick();
        tests_run++; if ({write, write_reg, write_data} !== {1'b1, 2'd1, 8'h20}) begin tests_failed++; $display("[TB] FAIL byp_no_coalesce: got %0b/%0d/%h expected 1/1/20", write, write_reg, write_data); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'(i), 8'hC0 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 2'd3, 8'h77, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        chk_reg1 = 2'd3;
        chk_reg2 = 2'd0;
        #1;
        tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_write: got %0b expected 0", write); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_ready: got %0b expected 1", in_ready); end
        tests_run++; if ({fwd_hit1, fwd_hit2} !== 2'b00) begin tests_failed++; $display("[TB] FAIL flush_fwd: got %b expected 00", {fwd_hit1, fwd_hit2}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_no_strobe_%0d: got %0b expected 0", i, write); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        applyStimulus(1'b1, 2'd0, 8'hA1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd1, 8'hB2, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd2, 8'hC3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        tests_run++; if ({write, write_reg, write_data} !== {1'b1, 2'd0, 8'hA1}) begin tests_failed++; $display("[TB] FAIL b2b_first: got %0b/%0d/%h expected 1/0/a1", write, write_reg, write_data); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_ready: got %0b expected 1", in_ready); end
        tick();
        tests_run++; if ({write, write_reg, write_data} !== {1'b1, 2'd1, 8'hB2}) begin tests_failed++; $display("[TB] FAIL b2b_second: got %0b/%0d/%h expected 1/1/b2", write, write_reg, write_data); end
        tick();
        tests_run++; if ({write, write_reg, write_data} !== {1'b1, 2'd2, 8'hC3}) begin tests_failed++; $display("[TB] FAIL b2b_third: got %0b/%0d/%h expected 1/2/c3", write, write_reg, write_data); end
        tick();
        tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_done: got %0b expected 0", write); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        applyStimulus(1'b1, 2'd3, 8'h9C, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'd2, 8'h3D, 1'b0, 1'b0);
        tick();
        tests_run++; if ({write, write_reg, write_data} !== {1'b1, 2'd3, 8'h9C}) begin tests_failed++; $display("[TB] FAIL rstmid_pre: got %0b/%0d/%h expected 1/3/9c", write, write_reg, write_data); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        chk_reg1 = 2'd3;
        chk_reg2 = 2'd2;
        #1;
        tests_run++; if ({write, write_reg, write_data} !== {1'b0, 2'd0, 8'h00}) begin tests_failed++; $display("[TB] FAIL rstmid_out: got %0b/%0d/%h expected 0/0/00", write, write_reg, write_data); end
        tests_run++; if ({in_ready, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== {1'b1, 2'b00, 16'h0000}) begin tests_failed++; $display("[TB] FAIL rstmid_misc: got %0b/%0b/%0b/%h/%h expected 1/0/0/00/00", in_ready, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2); end
        tick();
        tests_run++; if (write !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_discard: got %0b expected 0", write); end
    endtask

    task automatic test_random();
        logic       e_hit1;
        logic       e_hit2;
        logic [7:0] e_d1;
        logic [7:0] e_d2;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(99) < 60), 2'($urandom_range(3)), 8'($urandom),
                          ($urandom_range(99) < 35), ($urandom_range(99) < 3));
            chk_reg1 = 2'($urandom_range(3));
            chk_reg2 = 2'($urandom_range(3));
            tick();
            model_fwd(chk_reg1, e_hit1, e_d1);
            model_fwd(chk_reg2, e_hit2, e_d2);
            tests_run++;
            if (write !== m_write || (m_write && (write_reg !== m_reg || write_data !== m_data))) begin
                tests_failed++;
                $display("[TB] FAIL rand_out_%0d: got %0b/%0d/%h expected %0b/%0d/%h", n, write, write_reg, write_data, m_write, m_reg, m_data);
            end
            tests_run++;
            if (in_ready !== (mq.size() != DEPTH)) begin
                tests_failed++;
                $display("[TB] FAIL rand_ready_%0d: got %0b expected %0b", n, in_ready, (mq.size() != DEPTH));
            end
            tests_run++;
            if ({fwd_hit1, fwd_data1, fwd_hit2, fwd_data2} !== {e_hit1, e_d1, e_hit2, e_d2}) begin
                tests_failed++;
                $display("[TB] FAIL rand_fwd_%0d: got %0b/%h %0b/%h expected %0b/%h %0b/%h", n, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, e_hit1, e_d1, e_hit2, e_d2);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_write      = 1'b0;
        m_reg        = 2'd0;
        m_data       = 8'd0;
        reset        = 1'b1;
        chk_reg1     = 2'd0;
        chk_reg2     = 2'd0;
        applyStimulus(1'b0, 2'd0, 8'd0, 1'b0, 1'b0);
        test_reset();
        test_latency();
        test_hold_fill();
        test_bypass();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
